// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the pipeline register chain and other perf counters.
// Holds the default counter width and a saturating increment helper.
package pipe_reg_chain_pkg;

    localparam int CNT_W_DEF = 16;

    // Works on any counter up to 64 bits; callers widen then truncate.
    function automatic logic [63:0] sat_inc(
        input logic [63:0] v,
        input int unsigned w
    );
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v == top) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One pipeline register slice with valid, hold, flush and bubble insertion.
// Flush wins over hold; a frozen upstream register feeds a bubble.
module pipe_reg_stage #(
    parameter int WIDTH      = 32,
    parameter bit FLUSH_ZERO = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             hold,
    input  logic             up_hold,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            if (FLUSH_ZERO) data <= '0;
        end else if (hold) begin
            valid <= valid;
            data  <= data;
        end else if (up_hold) begin
            valid <= 1'b0;
            if (FLUSH_ZERO) data <= '0;
        end else begin
            valid <= up_valid;
            data  <= up_data;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Chain of stallable, flushable pipeline registers between CPU stages.
// Also counts retired entries and bubbles at the tail register.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STAGES     = 4,
    parameter bit FLUSH_ZERO = 1'b1,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic [STAGES-1:0]       stall_i,
    input  logic [STAGES-1:0]       flush_i,
    output logic [STAGES-1:0]       valid_o,
    output logic [STAGES*WIDTH-1:0] data_o,
    output logic                    stall_o,
    output logic [CNT_W-1:0]        retire_cnt_o,
    output logic [CNT_W-1:0]        bubble_cnt_o
);

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] up_hold;
    logic [STAGES-1:0] up_valid;
    logic [WIDTH-1:0]  up_data  [STAGES];
    logic [WIDTH-1:0]  reg_data [STAGES];
    logic              retire;

    // A stall freezes its own register and everything upstream of it.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign hold[k] = |stall_i[STAGES-1:k];

        if (k == 0) begin : g_head
            assign up_hold[k]  = 1'b0;
            assign up_valid[k] = valid_i;
            assign up_data[k]  = data_i;
        end else begin : g_body
            assign up_hold[k]  = hold[k-1];
            assign up_valid[k] = valid_o[k-1];
            assign up_data[k]  = reg_data[k-1];
        end

        pipe_reg_stage #(
            .WIDTH      (WIDTH),
            .FLUSH_ZERO (FLUSH_ZERO)
        ) u_stage (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .flush    (flush_i[k]),
            .hold     (hold[k]),
            .up_hold  (up_hold[k]),
            .up_valid (up_valid[k]),
            .up_data  (up_data[k]),
            .valid    (valid_o[k]),
            .data     (reg_data[k])
        );

        assign data_o[k*WIDTH +: WIDTH] = reg_data[k];
    end

    assign stall_o = hold[0];
    assign retire  = valid_o[LAST] & ~hold[LAST] & ~flush_i[LAST];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            retire_cnt_o <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (retire)
                retire_cnt_o <= CNT_W'(sat_inc(64'(retire_cnt_o), CNT_W));
            if (!valid_o[LAST])
                bubble_cnt_o <= CNT_W'(sat_inc(64'(bubble_cnt_o), CNT_W));
        end
    end

endmodule
